// File: rtl/pot_spi_pkg.sv
// Shared encodings and constants for the potentiometer SPI master.
package pot_spi_pkg;

    // Command encodings; they also form the C1..C0 bits of the frame.
    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_INC   = 2'b01;
    localparam logic [1:0] CMD_DEC   = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam int FRAME_LONG  = 16;
    localparam int FRAME_SHORT = 8;
    // Transmission-order slot (0 = first bit) where the device drives CMDERR.
    localparam int CMDERR_SLOT = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_ERR
    } state_e;

    // Frame left-aligned in 16 bits so the first bit out is always bit 15.
    function automatic logic [15:0] build_frame(input logic [3:0] addr,
                                                input logic [1:0] cmd,
                                                input logic [8:0] wdata);
        if (cmd == CMD_INC || cmd == CMD_DEC)
            return {addr, cmd, 2'b11, 8'h00};
        return {addr, cmd, 1'b1, (cmd == CMD_WRITE) ? wdata : 9'h000};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period divider for SCLK. phase_q tracks which half of the SCLK period
// is running: 0 for the setup / high halves, 1 for the low / hold halves.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Count within the half period, flip phase at each half-period end.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign rise_tick = (cnt_q == LAST) &&  phase_q;
    assign fall_tick = (cnt_q == LAST) && !phase_q;

endmodule

// File: rtl/pot_spi_master.sv
// SPI mode-0 master for a bank of MCP41HVX1-class potentiometers with shared
// SCLK/MOSI/MISO and per-channel chip select / wiper latch.
module pot_spi_master
    import pot_spi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int DATA_W  = 9,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CH_W-1:0]   req_ch,
    input  logic [1:0]        req_cmd,
    input  logic [3:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [N_CH-1:0]   spi_cs_n,
    output logic [N_CH-1:0]   spi_wlat_n
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [15:0]         shreg_q, shreg_d;     // MOSI is always shreg_q[15]
    logic [DATA_W-1:0]   rx_q, rx_d;           // last DATA_W MISO bits
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic                err_q, err_d;
    logic                sclk_q, sclk_d;
    logic [N_CH-1:0]     cs_n_q, cs_n_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [8:0]          wdata;
    logic [3:0]          last_idx;
    logic                rise_tick, fall_tick, tick;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == ST_IDLE),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign tick     = rise_tick | fall_tick;
    assign last_idx = (cmd_q == CMD_WRITE || cmd_q == CMD_READ) ?
                      4'(FRAME_LONG - 1) : 4'(FRAME_SHORT - 1);

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cmd_d       = cmd_q;
        shreg_d     = shreg_q;
        rx_d        = rx_q;
        bit_idx_d   = bit_idx_q;
        err_d       = err_q;
        sclk_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        wdata       = '0;
        wdata[DATA_W-1:0] = req_data;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (int'(req_ch) >= N_CH) begin
                        state_d     = ST_ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_SETUP;
                        ch_d      = req_ch;
                        cmd_d     = req_cmd;
                        shreg_d   = build_frame(req_addr, req_cmd, wdata);
                        rx_d      = '0;
                        bit_idx_d = '0;
                        err_d     = 1'b0;
                    end
                end
            end
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                sclk_d = sclk_q;
                if (rise_tick) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[DATA_W-2:0], spi_miso};
                    if (bit_idx_q == 4'(CMDERR_SLOT) && !spi_miso) err_d = 1'b1;
                end
                if (fall_tick) begin
                    sclk_d = 1'b0;
                    if (bit_idx_q == last_idx) begin
                        state_d = ST_HOLD;
                        shreg_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = {shreg_q[14:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_data_d  = (cmd_q == CMD_READ) ? rx_q : '0;
                end
            end
            ST_GAP:  if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cs_n_d = '1;
        if (state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD})
            for (int i = 0; i < N_CH; i++)
                if (ch_d == CH_W'(i)) cs_n_d[i] = 1'b0;
    end

    // State and output registers; reset drops any frame in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cmd_q       <= CMD_WRITE;
            shreg_q     <= '0;
            rx_q        <= '0;
            bit_idx_q   <= '0;
            err_q       <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cmd_q       <= cmd_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
            bit_idx_q   <= bit_idx_d;
            err_q       <= err_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = !req_ready;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = shreg_q[15];
    assign spi_cs_n   = cs_n_q;
    assign spi_wlat_n = cs_n_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_pot_spi_master.sv
// Self-checking bench for pot_spi_master: directed scenarios plus random
// transactions against a frame-level reference model.
module tb_pot_spi_master;
    localparam int N_CH = 4, CH_W = 3, DATA_W = 9, CD = 4;

    logic              clk = 1'b0, rst = 1'b1;
    logic              req_valid = 1'b0, req_ready;
    logic [CH_W-1:0]   req_ch = '0;
    logic [1:0]        req_cmd = '0;
    logic [3:0]        req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;
    logic              rsp_valid, rsp_err, busy, spi_sclk, spi_mosi;
    logic              spi_miso = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic [N_CH-1:0]   spi_cs_n, spi_wlat_n;

    pot_spi_master #(.N_CH(N_CH), .CH_W(CH_W), .DATA_W(DATA_W), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_wlat_n(spi_wlat_n));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // Observations of one transaction, cycle 1 = first cycle after acceptance.
    int obs_rsp_cyc, obs_ready_cyc, obs_nrise, obs_cs_first, obs_cs_last, obs_cs_cnt;
    int obs_wlat_bad, obs_busy_bad, obs_rsp_cnt;
    logic obs_err;
    logic [DATA_W-1:0] obs_data;
    logic [15:0] obs_mosi;
    logic [N_CH-1:0] obs_cs_mask;

    // Reference expectations.
    int exp_rsp_cyc, exp_ready_cyc, exp_nbits, exp_cs_cnt;
    logic exp_err;
    logic [DATA_W-1:0] exp_data;
    logic [15:0] exp_frame;
    logic [N_CH-1:0] exp_mask;

    // Device-side MISO pattern: slot s (0 = first bit) holds miso[s].
    function automatic logic [15:0] mk_miso(input logic cmderr, input logic [8:0] d);
        logic [15:0] m = 16'hFFFF;
        m[6] = cmderr;
        for (int s = 7; s < 16; s++) m[s] = d[15-s];
        return m;
    endfunction

    task automatic model(input int ch, input logic [1:0] cmd, input logic [3:0] addr,
                         input logic [DATA_W-1:0] data, input logic [15:0] miso);
        if (ch >= N_CH) begin
            exp_nbits = 0; exp_rsp_cyc = 1; exp_ready_cyc = 2; exp_err = 1'b1;
            exp_data = '0; exp_frame = '0; exp_mask = '0; exp_cs_cnt = 0;
            return;
        end
        exp_nbits = (cmd == 2'd0 || cmd == 2'd3) ? 16 : 8;
        if (exp_nbits == 16)
            exp_frame = 16'(addr * 4096 + cmd * 1024 + 512 + ((cmd == 2'd0) ? data : 0));
        else
            exp_frame = 16'(addr * 16 + cmd * 4 + 3);
        exp_rsp_cyc   = 1 + 2 * CD * (exp_nbits + 1);
        exp_ready_cyc = exp_rsp_cyc + CD;
        exp_cs_cnt    = exp_rsp_cyc - 1;
        exp_err       = (miso[6] == 1'b0);
        exp_data      = '0;
        if (cmd == 2'd3)
            for (int s = 7; s < 16; s++) exp_data = {exp_data[DATA_W-2:0], miso[s]};
        exp_mask = N_CH'(1) << ch;
    endtask

    // Present a request and return at cycle 1 of the accepted transaction.
    task automatic send(input int ch, input logic [1:0] cmd, input logic [3:0] addr,
                        input logic [DATA_W-1:0] data, input bit keep);
        int w;
        req_ch = CH_W'(ch); req_cmd = cmd; req_addr = addr; req_data = data;
        req_valid = 1'b1;
        for (w = 0; w < 400 && !req_ready; w++) begin @(posedge clk); #1; end
        if (!req_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: ready=%0b required 1", req_ready);
        end
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // Act as the device and record pins until req_ready returns.
    task automatic observe(input logic [15:0] miso);
        int rises = 0;
        logic prev_sclk = 1'b0;
        obs_rsp_cyc = -1; obs_ready_cyc = -1; obs_cs_first = -1; obs_cs_last = -1;
        obs_cs_cnt = 0; obs_wlat_bad = 0; obs_busy_bad = 0; obs_rsp_cnt = 0;
        obs_err = 1'bx; obs_data = 'x; obs_mosi = '0; obs_cs_mask = '0;
        for (int k = 1; k <= 400; k++) begin
            if (spi_sclk && !prev_sclk) begin obs_mosi = {obs_mosi[14:0], spi_mosi}; rises++; end
            prev_sclk = spi_sclk;
            if (spi_cs_n !== '1) begin
                obs_cs_mask |= ~spi_cs_n;
                if (obs_cs_first < 0) obs_cs_first = k;
                obs_cs_last = k; obs_cs_cnt++;
            end
            if (spi_wlat_n !== spi_cs_n) obs_wlat_bad++;
            if (busy === req_ready) obs_busy_bad++;
            if (rsp_valid) begin obs_rsp_cnt++; obs_rsp_cyc = k; obs_err = rsp_err; obs_data = rsp_data; end
            if (req_ready) begin obs_ready_cyc = k; break; end
            spi_miso = (rises < 16) ? miso[rises] : 1'b0;
            @(posedge clk); #1;
        end
        obs_nrise = rises;
        spi_miso = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({spi_cs_n, spi_wlat_n} !== {2*N_CH{1'b1}}) begin miscompares++;
            $display("FAIL reset_cs: got %h want all ones", {spi_cs_n, spi_wlat_n}); end
        vectors++;
        if ({spi_sclk, spi_mosi, rsp_valid, rsp_err, rsp_data} !== '0) begin miscompares++;
            $display("FAIL reset_pins: got %h want 0", {spi_sclk, spi_mosi, rsp_valid, rsp_err, rsp_data}); end
        vectors++;
        if ({req_ready, busy} !== 2'b10) begin miscompares++;
            $display("FAIL reset_ready: got %b want 10", {req_ready, busy}); end
    endtask

    task automatic test_write();
        send(2, 2'd0, 4'd0, 9'h1A5, 1'b0);
        observe(16'hFFFF);
        vectors++; if (obs_mosi !== 16'b0000_00_1_110100101) begin miscompares++;
            $display("FAIL write_mosi: got %h want 03a5", obs_mosi); end
        vectors++; if (obs_cs_mask !== 4'b0100 || obs_cs_first != 1 || obs_cs_last != 136) begin miscompares++;
            $display("FAIL write_cs: mask %b first %0d last %0d want 0100 1 136", obs_cs_mask, obs_cs_first, obs_cs_last); end
        vectors++; if (obs_rsp_cyc != 137 || obs_rsp_cnt != 1) begin miscompares++;
            $display("FAIL write_rsp_cycle: got %0d (x%0d) want 137", obs_rsp_cyc, obs_rsp_cnt); end
        vectors++; if ({obs_err, obs_data} !== 10'h000) begin miscompares++;
            $display("FAIL write_rsp: err %b data %h want 0 0", obs_err, obs_data); end
        vectors++; if (obs_nrise != 16 || obs_wlat_bad != 0 || obs_ready_cyc != 141) begin miscompares++;
            $display("FAIL write_misc: rises %0d wlat_bad %0d ready %0d want 16 0 141", obs_nrise, obs_wlat_bad, obs_ready_cyc); end
    endtask

    task automatic test_read();
        send(0, 2'd3, 4'd0, 9'h1FF, 1'b0);
        observe(mk_miso(1'b1, 9'h0C3));
        vectors++; if ({obs_err, obs_data} !== {1'b0, 9'h0C3}) begin miscompares++;
            $display("FAIL read_rsp: err %b data %h want 0 0c3", obs_err, obs_data); end
        vectors++; if (obs_mosi !== 16'h0E00 || obs_cs_mask !== 4'b0001) begin miscompares++;
            $display("FAIL read_frame: mosi %h cs %b want 0e00 0001", obs_mosi, obs_cs_mask); end
    endtask

    task automatic test_inc();
        send(1, 2'd1, 4'd0, 9'h0, 1'b0);
        observe(16'h0000);
        vectors++; if (obs_nrise != 8 || obs_mosi !== 16'h0007) begin miscompares++;
            $display("FAIL inc_frame: rises %0d mosi %h want 8 0007", obs_nrise, obs_mosi); end
        vectors++; if (obs_err !== 1'b1 || obs_data !== '0) begin miscompares++;
            $display("FAIL inc_err: err %b data %h want 1 0", obs_err, obs_data); end
        vectors++; if (obs_rsp_cyc != 73 || obs_ready_cyc != 77) begin miscompares++;
            $display("FAIL inc_timing: rsp %0d ready %0d want 73 77", obs_rsp_cyc, obs_ready_cyc); end
    endtask

    task automatic test_bad_ch();
        send(5, 2'd0, 4'd3, 9'h055, 1'b0);
        observe(16'hFFFF);
        vectors++; if (obs_cs_cnt != 0 || obs_nrise != 0) begin miscompares++;
            $display("FAIL badch_pins: cs_cycles %0d rises %0d want 0 0", obs_cs_cnt, obs_nrise); end
        vectors++; if (obs_rsp_cyc != 1 || obs_err !== 1'b1 || obs_ready_cyc != 2) begin miscompares++;
            $display("FAIL badch_rsp: rsp %0d err %b ready %0d want 1 1 2", obs_rsp_cyc, obs_err, obs_ready_cyc); end
    endtask

    task automatic test_reset_midframe();
        int extra = 0;
        send(3, 2'd0, 4'd1, 9'h0AA, 1'b0);
        for (int k = 1; k < 50; k++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if ({spi_cs_n, spi_wlat_n, spi_sclk, rsp_valid, req_ready} !== {{2*N_CH{1'b1}}, 3'b001}) begin miscompares++;
            $display("FAIL midreset_pins: got %h want %h", {spi_cs_n, spi_wlat_n, spi_sclk, rsp_valid, req_ready}, {{2*N_CH{1'b1}}, 3'b001}); end
        for (int k = 0; k < 150; k++) begin if (rsp_valid) extra++; @(posedge clk); #1; end
        vectors++; if (extra != 0) begin miscompares++;
            $display("FAIL midreset_rsp: got %0d pulses want 0", extra); end
        send(3, 2'd0, 4'd1, 9'h0AA, 1'b0);
        observe(16'hFFFF);
        model(3, 2'd0, 4'd1, 9'h0AA, 16'hFFFF);
        vectors++; if (obs_mosi !== exp_frame || obs_rsp_cyc != exp_rsp_cyc || obs_err !== 1'b0) begin miscompares++;
            $display("FAIL midreset_after: mosi %h rsp %0d err %b want %h %0d 0", obs_mosi, obs_rsp_cyc, obs_err, exp_frame, exp_rsp_cyc); end
    endtask

    task automatic test_back_to_back();
        send(1, 2'd0, 4'd9, 9'h133, 1'b1);
        req_ch = 3'd2; req_cmd = 2'd2; req_addr = 4'd6; req_data = 9'h0FF;
        model(1, 2'd0, 4'd9, 9'h133, 16'hFFFF);
        observe(16'hFFFF);
        vectors++; if (obs_mosi !== exp_frame || obs_cs_mask !== exp_mask) begin miscompares++;
            $display("FAIL b2b_first: mosi %h cs %b want %h %b", obs_mosi, obs_cs_mask, exp_frame, exp_mask); end
        vectors++; if (obs_ready_cyc != 141 || !req_valid) begin miscompares++;
            $display("FAIL b2b_ready: got %0d want 141", obs_ready_cyc); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(2, 2'd2, 4'd6, 9'h0FF, 16'hFFFF);
        observe(16'hFFFF);
        vectors++; if (obs_mosi !== exp_frame || obs_cs_mask !== exp_mask || obs_rsp_cyc != exp_rsp_cyc) begin miscompares++;
            $display("FAIL b2b_second: mosi %h cs %b rsp %0d want %h %b %0d", obs_mosi, obs_cs_mask, obs_rsp_cyc, exp_frame, exp_mask, exp_rsp_cyc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int ch = $urandom_range(0, 5);
            logic [1:0] cmd = 2'($urandom_range(0, 3));
            logic [3:0] addr = 4'($urandom);
            logic [DATA_W-1:0] data = DATA_W'($urandom);
            logic [15:0] miso = 16'($urandom);
            model(ch, cmd, addr, data, miso);
            send(ch, cmd, addr, data, 1'b0);
            observe(miso);
            vectors++; if (obs_mosi !== exp_frame || obs_nrise != exp_nbits) begin miscompares++;
                $display("FAIL rand%0d_frame: mosi %h rises %0d want %h %0d", n, obs_mosi, obs_nrise, exp_frame, exp_nbits); end
            vectors++; if (obs_cs_mask !== exp_mask || obs_cs_cnt != exp_cs_cnt) begin miscompares++;
                $display("FAIL rand%0d_cs: mask %b cycles %0d want %b %0d", n, obs_cs_mask, obs_cs_cnt, exp_mask, exp_cs_cnt); end
            vectors++; if (obs_rsp_cyc != exp_rsp_cyc || obs_ready_cyc != exp_ready_cyc || obs_rsp_cnt != 1) begin miscompares++;
                $display("FAIL rand%0d_timing: rsp %0d ready %0d want %0d %0d", n, obs_rsp_cyc, obs_ready_cyc, exp_rsp_cyc, exp_ready_cyc); end
            vectors++; if (obs_err !== exp_err || obs_data !== exp_data) begin miscompares++;
                $display("FAIL rand%0d_rsp: err %b data %h want %b %h", n, obs_err, obs_data, exp_err, exp_data); end
            vectors++; if (obs_wlat_bad != 0 || obs_busy_bad != 0) begin miscompares++;
                $display("FAIL rand%0d_aux: wlat_bad %0d busy_bad %0d want 0 0", n, obs_wlat_bad, obs_busy_bad); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_write();
        test_read();
        test_inc();
        test_bad_ch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
